multicycle_controller: RTL and testbench

- Control FSM for the multicycle RISC-V core. It sequences the shared datapath: one memory port, one ALU, the IR/OldPC/Data/ALUOut registers and the register file.
- Each instruction is broken into 3–5 states. The block drives mux selects and write enables per state.
- It waits on a single-bit memory-ready handshake and flags unsupported opcodes.
- Supported instructions: lw, sw, R-type, I-type ALU, beq, jal.

---
 rtl/multicycle_controller_pkg.sv | 61 ++++++
 rtl/multicycle_controller_imm_src_decoder.sv | 27 ++
 rtl/multicycle_controller.sv | 170 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module : multicycle_controller_pkg
//  Brief  : Shared opcode constants, FSM state encodings and datapath select
//           codes for the multicycle RISC-V controller.
//  Rev    : 1.0  initial release
// ============================================================================
package multicycle_controller_pkg;

  // RV32I major opcodes handled by the controller
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // FSM state encodings; codes 12..15 are unreachable
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_FAULT    = 4'd11
  } state_e;

  // ResultSrc
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALUSrcA
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  // ALUSrcB
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALUOp
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ImmSrc
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_imm_src_decoder.sv
`default_nettype none
// ============================================================================
//  Module : imm_src_decoder
//  Brief  : Combinational opcode -> immediate-format select.
//  Ports  : op      in  7  opcode field of the IR
//           imm_src out 2  immediate format (I/S/B/J)
//  Rev    : 1.0  initial release
// ============================================================================
module imm_src_decoder
  import multicycle_controller_pkg::*;
(
  input  logic [6:0] op,
  output logic [1:0] imm_src
);

  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_STORE:  imm_src = IMM_S;
      OP_BRANCH: imm_src = IMM_B;
      OP_JAL:    imm_src = IMM_J;
      default:   imm_src = IMM_I;   // lw, I-ALU and anything unsupported
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module : multicycle_controller
//  Brief  : Control FSM for the multicycle RISC-V core. Sequences the shared
//           memory port, ALU and architectural registers one state per cycle.
//  Ports  : clk, rst            clock / async active-high reset
//           Op, Zero, MemReady  opcode, ALU zero flag, memory handshake
//           PCWrite, IRWrite, MemWrite, RegWrite   write enables
//           AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc  selects
//           InstrDone           pulse in the last state of an instruction
//           Illegal             sticky unsupported-opcode flag
//  Rev    : 1.0  initial release
// ============================================================================
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATE_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic       InstrDone,
  output logic       Illegal
);

  logic [STATE_W-1:0] state, state_nxt;
  logic               illegal_q;
  logic               mem_rdy;
  logic               pc_we, ir_we, mem_we, reg_we, done;

  assign mem_rdy = (MEM_HANDSHAKE != 0) ? MemReady : 1'b1;

  imm_src_decoder u_imm_src_decoder (
    .op      (Op),
    .imm_src (ImmSrc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= STATE_W'(S_FETCH);
      illegal_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == STATE_W'(S_FAULT))
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = STATE_W'(S_FETCH);
    case (state)
      STATE_W'(S_FETCH):
        state_nxt = mem_rdy ? STATE_W'(S_DECODE) : STATE_W'(S_FETCH);
      STATE_W'(S_DECODE): begin
        case (Op)
          OP_LOAD, OP_STORE: state_nxt = STATE_W'(S_MEMADR);
          OP_RTYPE:          state_nxt = STATE_W'(S_EXECR);
          OP_ITYPE:          state_nxt = STATE_W'(S_EXECI);
          OP_BRANCH:         state_nxt = STATE_W'(S_BEQ);
          OP_JAL:            state_nxt = STATE_W'(S_JAL);
          default:           state_nxt = STATE_W'(S_FAULT);
        endcase
      end
      STATE_W'(S_MEMADR):
        state_nxt = (Op == OP_LOAD) ? STATE_W'(S_MEMREAD) : STATE_W'(S_MEMWRITE);
      STATE_W'(S_MEMREAD):
        state_nxt = mem_rdy ? STATE_W'(S_MEMWB) : STATE_W'(S_MEMREAD);
      STATE_W'(S_MEMWRITE):
        state_nxt = mem_rdy ? STATE_W'(S_FETCH) : STATE_W'(S_MEMWRITE);
      STATE_W'(S_EXECR), STATE_W'(S_EXECI), STATE_W'(S_JAL):
        state_nxt = STATE_W'(S_ALUWB);
      STATE_W'(S_FAULT):
        state_nxt = STATE_W'(S_FAULT);
      default:                          // MEMWB, ALUWB, BEQ and unreachable codes
        state_nxt = STATE_W'(S_FETCH);
    endcase
  end

  // Moore decode; PCWrite/IRWrite additionally follow MemReady (FETCH) and
  // Zero (BEQ). Unlisted selects stay 00 and unlisted enables stay 0.
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_we    = 1'b0;
    reg_we    = 1'b0;
    done      = 1'b0;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ALUOp     = ALUOP_ADD;
    case (state)
      STATE_W'(S_FETCH): begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
      end
      STATE_W'(S_DECODE): begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
      end
      STATE_W'(S_MEMADR): begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
      end
      STATE_W'(S_MEMREAD): AdrSrc = 1'b1;
      STATE_W'(S_MEMWB): begin
        ResultSrc = RES_DATA;
        reg_we    = 1'b1;
        done      = 1'b1;
      end
      STATE_W'(S_MEMWRITE): begin
        AdrSrc = 1'b1;
        mem_we = 1'b1;
        done   = mem_rdy;
      end
      STATE_W'(S_EXECR): begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_FUNCT;
      end
      STATE_W'(S_EXECI): begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALUOP_FUNCT;
      end
      STATE_W'(S_ALUWB): begin
        reg_we = 1'b1;
        done   = 1'b1;
      end
      STATE_W'(S_BEQ): begin
        ALUSrcA = SRCA_RD1;
        ALUOp   = ALUOP_SUB;
        pc_we   = Zero;
        done    = 1'b1;
      end
      STATE_W'(S_JAL): begin
        // PC takes the target latched in DECODE; ALU forms the link OldPC+4
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pc_we   = 1'b1;
      end
      default: ;                        // FAULT and unreachable codes: all idle
    endcase
  end

  // Reset forces FETCH, whose enables depend on MemReady; mask them so no
  // write strobe can leak out while rst is held.
  assign PCWrite   = pc_we  & ~rst;
  assign IRWrite   = ir_we  & ~rst;
  assign MemWrite  = mem_we & ~rst;
  assign RegWrite  = reg_we & ~rst;
  assign InstrDone = done   & ~rst;
  assign Illegal   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
//  Module : tb_multicycle_controller
//  Brief  : Self-checking bench for multicycle_controller: a table of
//           per-cycle vectors plus hand-written stall / reset / fault runs.
//  Rev    : 1.0  initial release
// ============================================================================
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, InstrDone, Illegal;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011,
                         IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111,
                         BAD = 7'b1111111;

  always #5 clk = ~clk;

  multicycle_controller #(.MEM_HANDSHAKE(1), .STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .InstrDone(InstrDone), .Illegal(Illegal)
  );

  // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUOp,ImmSrc,
  //  RegWrite,InstrDone,Illegal}
  wire [16:0] act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                     ALUSrcB, ALUOp, ImmSrc, RegWrite, InstrDone, Illegal};

  function automatic logic [16:0] e(input logic pcw, adr, mw, irw,
                                    input logic [1:0] rs, a, b, aop, imm,
                                    input logic rw, d, ill);
    return {pcw, adr, mw, irw, rs, a, b, aop, imm, rw, d, ill};
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    case (op)
      SW:      return 2'b01;
      BQ:      return 2'b10;
      JL:      return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Expected output words per state, written straight from the state table
  function automatic logic [16:0] x_fetch(input logic [6:0] op, input logic mr);
    return e(mr, 0, 0, mr, 2'b10, 2'b00, 2'b10, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_rst(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_decode(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_memadr(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_memread(input logic [6:0] op);
    return e(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_memwb(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, imm_of(op), 1, 1, 0);
  endfunction
  function automatic logic [16:0] x_memwrite(input logic [6:0] op, input logic mr);
    return e(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 0, mr, 0);
  endfunction
  function automatic logic [16:0] x_execr(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_execi(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_aluwb(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 1, 1, 0);
  endfunction
  function automatic logic [16:0] x_beq(input logic [6:0] op, input logic z);
    return e(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, imm_of(op), 0, 1, 0);
  endfunction
  function automatic logic [16:0] x_jal(input logic [6:0] op);
    return e(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, imm_of(op), 0, 0, 0);
  endfunction
  function automatic logic [16:0] x_fault(input logic [6:0] op);
    return e(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, imm_of(op), 0, 0, 1);
  endfunction

  typedef struct {
    string      name;
    logic [6:0] op;
    logic       zero;
    logic       mr;
    logic [16:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string nm, input logic [6:0] op, input logic z,
                     input logic mr, input logic [16:0] ex);
    vec_t v;
    v.name = nm; v.op = op; v.zero = z; v.mr = mr; v.exp = ex;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [16:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got=%b required=%b", nm, act, ex);
    end
  endtask

  // Inputs change at posedge+1; outputs are checked at posedge+3.
  task automatic drive(input logic [6:0] op, input logic z, input logic mr);
    Op = op; Zero = z; MemReady = mr;
    #2;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; Op = LW; Zero = 1'b0; MemReady = 1'b1;

    // Table: back-to-back instructions with MemReady=1, one row per cycle
    add("lw_fetch",   LW, 0, 1, x_fetch(LW, 1));
    add("lw_decode",  LW, 0, 1, x_decode(LW));
    add("lw_memadr",  LW, 0, 1, x_memadr(LW));
    add("lw_memread", LW, 0, 1, x_memread(LW));
    add("lw_memwb",   LW, 0, 1, x_memwb(LW));
    add("r_fetch",    RT, 0, 1, x_fetch(RT, 1));
    add("r_decode",   RT, 0, 1, x_decode(RT));
    add("r_execr",    RT, 0, 1, x_execr(RT));
    add("r_aluwb",    RT, 0, 1, x_aluwb(RT));
    add("i_fetch",    IT, 0, 1, x_fetch(IT, 1));
    add("i_decode",   IT, 0, 1, x_decode(IT));
    add("i_execi",    IT, 0, 1, x_execi(IT));
    add("i_aluwb",    IT, 0, 1, x_aluwb(IT));
    add("sw_fetch",   SW, 0, 1, x_fetch(SW, 1));
    add("sw_decode",  SW, 0, 1, x_decode(SW));
    add("sw_memadr",  SW, 0, 1, x_memadr(SW));
    add("sw_memwr",   SW, 0, 1, x_memwrite(SW, 1));
    add("beq1_fetch", BQ, 1, 1, x_fetch(BQ, 1));
    add("beq1_dec",   BQ, 1, 1, x_decode(BQ));
    add("beq1_beq",   BQ, 1, 1, x_beq(BQ, 1));
    add("beq0_fetch", BQ, 0, 1, x_fetch(BQ, 1));
    add("beq0_dec",   BQ, 0, 1, x_decode(BQ));
    add("beq0_beq",   BQ, 0, 1, x_beq(BQ, 0));
    add("jal_fetch",  JL, 0, 1, x_fetch(JL, 1));
    add("jal_decode", JL, 0, 1, x_decode(JL));
    add("jal_jal",    JL, 0, 1, x_jal(JL));
    add("jal_aluwb",  JL, 0, 1, x_aluwb(JL));
    add("next_fetch", RT, 0, 1, x_fetch(RT, 1));

    // Reset state, with MemReady high so unmasked FETCH enables would show
    repeat (2) @(posedge clk);
    #3;
    chk("reset_hold", x_rst(LW));
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].op, tbl[i].zero, tbl[i].mr);
      chk(tbl[i].name, tbl[i].exp);
      step();
    end
    // Now in DECODE of the R-type started by the last row; run it out.
    drive(RT, 0, 1); chk("r2_decode", x_decode(RT)); step();
    drive(RT, 0, 1); chk("r2_execr", x_execr(RT));   step();
    drive(RT, 0, 1); chk("r2_aluwb", x_aluwb(RT));   step();

    // FETCH stall, then async reset in the middle of EXECR
    for (int k = 0; k < 2; k++) begin
      drive(RT, 0, 0); chk("fetch_stall", x_fetch(RT, 0)); step();
    end
    drive(RT, 0, 1); chk("fetch_go", x_fetch(RT, 1)); step();
    drive(RT, 0, 1); chk("rst_decode", x_decode(RT)); step();
    drive(RT, 0, 1); chk("rst_execr", x_execr(RT));
    #1 rst = 1'b1;
    #1 chk("rst_async_now", x_rst(RT));
    @(posedge clk);
    #1 chk("rst_held_edge", x_rst(RT));
    rst = 1'b0;
    drive(RT, 0, 1); chk("rst_restart", x_fetch(RT, 1)); step();
    drive(RT, 0, 1); chk("rst_decode2", x_decode(RT)); step();
    drive(RT, 0, 1); chk("rst_execr2", x_execr(RT)); step();
    drive(RT, 0, 1); chk("rst_aluwb2", x_aluwb(RT)); step();

    // lw with one stall cycle in MEMREAD
    drive(LW, 0, 1); chk("lws_fetch", x_fetch(LW, 1)); step();
    drive(LW, 0, 1); chk("lws_decode", x_decode(LW)); step();
    drive(LW, 0, 1); chk("lws_memadr", x_memadr(LW)); step();
    drive(LW, 0, 0); chk("lws_rd_stall", x_memread(LW)); step();
    drive(LW, 0, 1); chk("lws_rd_go", x_memread(LW)); step();
    drive(LW, 0, 1); chk("lws_memwb", x_memwb(LW)); step();

    // sw with MemReady low for 3 cycles in MEMWRITE
    drive(SW, 0, 1); chk("sws_fetch", x_fetch(SW, 1)); step();
    drive(SW, 0, 1); chk("sws_decode", x_decode(SW)); step();
    drive(SW, 0, 1); chk("sws_memadr", x_memadr(SW)); step();
    for (int k = 0; k < 3; k++) begin
      drive(SW, 0, 0); chk("sws_wr_stall", x_memwrite(SW, 0)); step();
    end
    drive(SW, 0, 1); chk("sws_wr_go", x_memwrite(SW, 1)); step();
    drive(SW, 0, 0); chk("sws_back_fetch", x_fetch(SW, 0)); step();

    // Unsupported opcode: DECODE -> FAULT, sticky, then cleared by reset
    drive(BAD, 0, 1); chk("bad_fetch", x_fetch(BAD, 1)); step();
    drive(BAD, 0, 1); chk("bad_decode", x_decode(BAD)); step();
    for (int k = 0; k < 10; k++) begin
      drive(BAD, k[0], k[1]);
      chk("fault_hold", x_fault(BAD));
      step();
    end
    drive(BAD, 0, 1);
    rst = 1'b1;
    #1 chk("fault_rst", x_rst(BAD));
    @(posedge clk);
    #1 rst = 1'b0;
    drive(LW, 0, 1); chk("fault_restart", x_fetch(LW, 1)); step();
    drive(LW, 0, 1); chk("fault_decode", x_decode(LW)); step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
